// File: rtl/instr_encoder_loader.sv
// Boot-path instruction loader: packs symbolic instruction fields into 32-bit words,
// buffers them in a small FIFO and writes them sequentially into IMEM from a base address.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | accepting field sets, encoding, writing IMEM
// DONE  | one-cycle completion pulse, then IDLE
module instr_encoder_loader #(
    parameter int DEPTH     = 4,
    parameter int AW        = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic          last,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_op,
    input  logic [3:0]    in_rd,
    input  logic [3:0]    in_rs1,
    input  logic [3:0]    in_rs2,
    input  logic [31:0]   in_imm,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ready,
    output logic          busy,
    output logic          done,
    output logic          err_illegal,
    output logic          err_range,
    output logic [AW:0]   word_count
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t        state;
    logic [AW-1:0] addrCnt;
    logic [AW:0]   wordCnt;
    logic          lastSeen;
    logic          pipeValid;
    logic [31:0]   pipeWord;
    logic [31:0]   fifoMem [DEPTH];
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] wrPtr;
    logic [PW:0]   fifoCount;

    logic          isI, isSB, isR;
    logic          immOk, illegal, rangeErr;
    logic [31:0]   encWord;
    logic [31:0]   occupancy;
    logic          fifoFull, capFull, xfer, pop;

    always_comb begin
        isI = 1'b0;
        isSB = 1'b0;
        isR = 1'b0;
        case (in_op)
            5'b00000, 5'b01101, 5'b00011, 5'b01001, 5'b01100: isI = 1'b1;
            5'b00001, 5'b00111, 5'b01000: isSB = 1'b1;
            5'b00100, 5'b00101, 5'b00110, 5'b01010, 5'b01110, 5'b01111,
            5'b10000, 5'b10001, 5'b10010, 5'b10100, 5'b10101, 5'b10110,
            5'b10111, 5'b11000: isR = 1'b1;
            default: ;
        endcase
        immOk = (in_imm[31:18] == '0) || (in_imm[31:18] == '1);
        illegal = !(isI || isSB || isR);
        rangeErr = (isI || isSB) && !immOk;

        encWord = '0;
        encWord[31:27] = in_op;
        encWord[22:19] = in_rs1;
        if (isSB) begin
            encWord[26:23] = in_imm[3:0];
            encWord[18:15] = in_rs2;
            encWord[14:0]  = in_imm[18:4];
        end else if (isI) begin
            encWord[26:23] = in_rd;
            encWord[18:0]  = in_imm[18:0];
        end else begin
            encWord[26:23] = in_rd;
            encWord[18:15] = in_rs2;
        end
    end

    // Occupancy counts the encode register so an accepted word always has a FIFO slot.
    assign occupancy = 32'(fifoCount) + 32'(pipeValid);
    assign fifoFull  = occupancy >= 32'(DEPTH);
    assign capFull   = (32'(wordCnt) + occupancy) >= 32'(MAX_WORDS);
    assign in_ready  = (state == LOAD) && !lastSeen && !fifoFull && !capFull;
    assign xfer      = in_valid && in_ready;
    assign mem_we    = (state == LOAD) && (fifoCount != '0);
    assign pop       = mem_we && mem_ready;
    assign mem_addr  = addrCnt;
    assign mem_wdata = mem_we ? fifoMem[rdPtr] : '0;
    assign word_count = wordCnt;

    always_ff @(posedge clk) begin
        if (state == LOAD && pipeValid)
            fifoMem[wrPtr] <= pipeWord;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            addrCnt     <= '0;
            wordCnt     <= '0;
            lastSeen    <= 1'b0;
            pipeValid   <= 1'b0;
            pipeWord    <= '0;
            rdPtr       <= '0;
            wrPtr       <= '0;
            fifoCount   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_illegal <= 1'b0;
            err_range   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (start) begin
                        state       <= LOAD;
                        busy        <= 1'b1;
                        addrCnt     <= base_addr;
                        wordCnt     <= '0;
                        lastSeen    <= 1'b0;
                        pipeValid   <= 1'b0;
                        rdPtr       <= '0;
                        wrPtr       <= '0;
                        fifoCount   <= '0;
                        err_illegal <= 1'b0;
                        err_range   <= 1'b0;
                    end
                end
                LOAD: begin
                    pipeValid <= xfer && !illegal && !rangeErr;
                    if (xfer) begin
                        pipeWord <= encWord;
                        if (illegal)
                            err_illegal <= 1'b1;
                        else if (rangeErr)
                            err_range <= 1'b1;
                        if (last)
                            lastSeen <= 1'b1;
                    end
                    if (pipeValid)
                        wrPtr <= wrPtr + PW'(1);
                    if (pop) begin
                        rdPtr   <= rdPtr + PW'(1);
                        addrCnt <= addrCnt + AW'(1);
                        wordCnt <= wordCnt + (AW+1)'(1);
                    end
                    fifoCount <= fifoCount + (PW+1)'(pipeValid) - (PW+1)'(pop);
                    if (lastSeen && fifoCount == '0 && !pipeValid) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: packing per opcode class, error flags,
// IMEM backpressure, address wrap and asynchronous abort.
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  base_addr = '0;
    logic        last = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_op = '0;
    logic [3:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [31:0] in_imm = '0;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic        busy, done, err_illegal, err_range;
    logic [10:0] word_count;

    int nCompared = 0;
    int nMismatch = 0;
    int cyc = 0;
    int weCount = 0;
    logic [9:0]  wAddr[$];
    logic [31:0] wData[$];
    int          wCyc[$];

    instr_encoder_loader #(.DEPTH(4), .AW(10), .MAX_WORDS(1024)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .last(last),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .busy(busy), .done(done), .err_illegal(err_illegal), .err_range(err_range),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) weCount <= weCount + 1;
        if (mem_we && mem_ready) begin
            wAddr.push_back(mem_addr);
            wData.push_back(mem_wdata);
            wCyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatch++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearLog();
        wAddr.delete();
        wData.delete();
        wCyc.delete();
    endtask

    task automatic startSession(input logic [9:0] b);
        base_addr = b;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                        input logic [3:0] rs2, input logic [31:0] imm, input logic lst);
        logic ok;
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        last = lst;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (in_ready) begin
                step();
                ok = 1'b1;
                break;
            end
            step();
        end
        in_valid = 1'b0;
        last = 1'b0;
        check("send_accepted", 64'(ok), 64'd1);
    endtask

    task automatic waitDone();
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        check("done_pulse", 64'(seen), 64'd1);
        step();
        check("done_one_cycle", 64'(done), 64'd0);
        check("busy_after_done", 64'(busy), 64'd0);
    endtask

    task automatic expectWrite(input int idx, input logic [9:0] a, input logic [31:0] d);
        check($sformatf("wr%0d_addr", idx), (idx < wAddr.size()) ? 64'(wAddr[idx]) : 64'hx, 64'(a));
        check($sformatf("wr%0d_data", idx), (idx < wData.size()) ? 64'(wData[idx]) : 64'hx, 64'(d));
    endtask

    initial begin
        logic [31:0] seqWord [5];
        logic [9:0]  holdAddr;
        logic [31:0] holdData;
        int          changes;
        seqWord[0] = 32'h2088_8000;
        seqWord[1] = 32'h2111_0000;
        seqWord[2] = 32'h2199_8000;
        seqWord[3] = 32'h2222_0000;
        seqWord[4] = 32'h22AA_8000;

        // Reset values
        step(); step();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_flags", 64'({busy, done, err_illegal, err_range}), 64'd0);
        check("rst_word_count", 64'(word_count), 64'd0);
        rst = 1'b0;
        mem_ready = 1'b1;
        step();

        // Session 1: three R-type words from 0x010
        clearLog();
        startSession(10'h010);
        check("s1_busy", 64'(busy), 64'd1);
        send(5'b00100, 4'd1, 4'd2, 4'd3, 32'h0, 1'b0);
        send(5'b00100, 4'd1, 4'd2, 4'd3, 32'h0, 1'b0);
        send(5'b00100, 4'd1, 4'd2, 4'd3, 32'h0, 1'b1);
        waitDone();
        check("s1_word_count", 64'(word_count), 64'd3);
        check("s1_nwrites", 64'(wAddr.size()), 64'd3);
        for (int i = 0; i < 3; i++) expectWrite(i, 10'h010 + 10'(i), 32'h2091_8000);

        // Session 2: I boundaries, range error, SB, illegal, vector
        clearLog();
        startSession(10'h020);
        send(5'b00000, 4'd5, 4'd6, 4'd0, 32'hFFFF_FFFF, 1'b0);
        send(5'b00000, 4'd5, 4'd6, 4'd0, 32'h0004_0000, 1'b0);
        check("s2_err_range_set", 64'(err_range), 64'd1);
        check("s2_err_illegal_clear", 64'(err_illegal), 64'd0);
        send(5'b01101, 4'd0, 4'd0, 4'd0, 32'hFFFC_0000, 1'b0);
        send(5'b00001, 4'd9, 4'd2, 4'd3, 32'h0001_2345, 1'b0);
        send(5'b00010, 4'd1, 4'd2, 4'd3, 32'h0, 1'b0);
        check("s2_err_illegal_set", 64'(err_illegal), 64'd1);
        send(5'b10000, 4'd1, 4'd2, 4'd3, 32'hDEAD_BEEF, 1'b1);
        waitDone();
        check("s2_word_count", 64'(word_count), 64'd4);
        check("s2_sticky", 64'({err_illegal, err_range}), 64'b11);
        check("s2_nwrites", 64'(wAddr.size()), 64'd4);
        expectWrite(0, 10'h020, 32'h02B7_FFFF);
        expectWrite(1, 10'h021, 32'h6804_0000);
        expectWrite(2, 10'h022, 32'h0A91_9234);
        expectWrite(3, 10'h023, 32'h8091_8000);

        // Session 3: illegal op with out-of-range imm and last -> only err_illegal, session ends
        clearLog();
        startSession(10'h030);
        check("s3_err_cleared", 64'({err_illegal, err_range}), 64'b00);
        send(5'b00010, 4'd0, 4'd0, 4'd0, 32'h0004_0000, 1'b1);
        waitDone();
        check("s3_flags", 64'({err_illegal, err_range}), 64'b10);
        check("s3_word_count", 64'(word_count), 64'd0);
        check("s3_nwrites", 64'(wAddr.size()), 64'd0);

        // Session 4: IMEM stalls, FIFO fills, order preserved, restart ignored
        clearLog();
        mem_ready = 1'b0;
        startSession(10'h100);
        for (int i = 0; i < 4; i++)
            send(5'b00100, 4'(i + 1), 4'(i + 1), 4'(i + 1), 32'h0, 1'b0);
        step();
        check("s4_full_in_ready", 64'(in_ready), 64'd0);
        check("s4_mem_we", 64'(mem_we), 64'd1);
        check("s4_head_addr", 64'(mem_addr), 64'h100);
        check("s4_head_data", 64'(mem_wdata), 64'(seqWord[0]));
        base_addr = 10'h200;
        start = 1'b1;
        holdAddr = mem_addr;
        holdData = mem_wdata;
        changes = 0;
        for (int n = 0; n < 10; n++) begin
            step();
            start = 1'b0;
            if (mem_addr !== holdAddr || mem_wdata !== holdData || in_ready !== 1'b0) changes++;
        end
        check("s4_stall_stable", 64'(changes), 64'd0);
        check("s4_no_writes_stalled", 64'(wAddr.size()), 64'd0);
        mem_ready = 1'b1;
        send(5'b00100, 4'd5, 4'd5, 4'd5, 32'h0, 1'b1);
        waitDone();
        check("s4_word_count", 64'(word_count), 64'd5);
        check("s4_nwrites", 64'(wAddr.size()), 64'd5);
        for (int i = 0; i < 5; i++) expectWrite(i, 10'h100 + 10'(i), seqWord[i]);
        for (int i = 1; i < 5; i++)
            check($sformatf("s4_nogap%0d", i),
                  (i < wCyc.size()) ? 64'(wCyc[i] - wCyc[i-1]) : 64'hx, 64'd1);

        // Session 5: address wrap
        clearLog();
        startSession(10'h3FF);
        send(5'b00100, 4'd1, 4'd1, 4'd1, 32'h0, 1'b0);
        send(5'b00100, 4'd2, 4'd2, 4'd2, 32'h0, 1'b1);
        waitDone();
        check("s5_word_count", 64'(word_count), 64'd2);
        expectWrite(0, 10'h3FF, seqWord[0]);
        expectWrite(1, 10'h000, seqWord[1]);

        // Session 6: asynchronous abort mid-stream
        clearLog();
        mem_ready = 1'b0;
        startSession(10'h050);
        send(5'b00100, 4'd1, 4'd1, 4'd1, 32'h0, 1'b0);
        send(5'b00100, 4'd2, 4'd2, 4'd2, 32'h0, 1'b0);
        step();
        check("s6_pending_we", 64'(mem_we), 64'd1);
        rst = 1'b1;
        step();
        check("s6_rst_mem_we", 64'(mem_we), 64'd0);
        check("s6_rst_outputs", 64'({in_ready, busy, done, err_illegal, err_range}), 64'd0);
        check("s6_rst_addr_data", 64'({mem_addr, mem_wdata}), 64'd0);
        check("s6_rst_word_count", 64'(word_count), 64'd0);
        mem_ready = 1'b1;
        rst = 1'b0;
        weCount = 0;
        for (int n = 0; n < 10; n++) step();
        check("s6_no_we_after_abort", 64'(weCount), 64'd0);
        check("s6_no_writes", 64'(wAddr.size()), 64'd0);
        check("s6_idle", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
